// File: rtl/rv_fpu_tag_buffer_pkg.sv
// Shared types and default widths for the FPU tag allocator and its metadata store.
// Release outcomes are classified here so related blocks can use the same encoding.
package rv_fpu_tag_buffer_pkg;

    localparam int unsigned TAG_BUF_DEF_TAGW  = 2;
    localparam int unsigned TAG_BUF_DEF_DATAW = 64;

    typedef enum logic [1:0] {
        REL_NONE = 2'd0,
        REL_OK   = 2'd1,
        REL_BAD  = 2'd2
    } rel_kind_e;

    // Classify a release request against the occupancy of its target slot.
    function automatic rel_kind_e classify_release(input logic valid, input logic slot_used);
        rel_kind_e kind;
        if (!valid) begin
            kind = REL_NONE;
        end else if (slot_used) begin
            kind = REL_OK;
        end else begin
            kind = REL_BAD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/rv_priority_encoder.sv
// Lowest-index-first priority encoder: returns the index of the lowest set request bit.
// valid_o is low and index_o is zero when no bit is set.
module rv_priority_encoder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]                       req_i,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] index_o,
    output logic                               valid_o
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        index_o = {IW{1'b0}};
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                index_o = IW'(i);
                valid_o = 1'b1;
            end else begin
                index_o = index_o;
            end
        end
    end

endmodule

// File: rtl/rv_fpu_tag_buffer.sv
// Tag allocator and metadata store in front of the FPU. Grants the lowest free tag,
// parks per-instruction metadata, and returns it (and frees the tag) when the result commits.
module rv_fpu_tag_buffer
    import rv_fpu_tag_buffer_pkg::*;
#(
    parameter int unsigned TAGW  = TAG_BUF_DEF_TAGW,
    parameter int unsigned DATAW = TAG_BUF_DEF_DATAW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [DATAW-1:0] alloc_data,
    output logic             alloc_ready,
    output logic [TAGW-1:0]  alloc_tag,
    input  logic             release_valid,
    input  logic [TAGW-1:0]  release_tag,
    output logic [DATAW-1:0] release_data,
    output logic [TAGW:0]    count,
    output logic             full,
    output logic             empty,
    output logic             err_release
);
    localparam int unsigned DEPTH = 2 ** TAGW;

    logic [DEPTH-1:0] used_q;
    logic [DEPTH-1:0] used_d;
    logic [TAGW:0]    count_q;
    logic [TAGW:0]    count_d;
    logic             err_q;
    logic             err_d;
    logic [DATAW-1:0] mem_q [DEPTH];

    logic [TAGW-1:0]  free_idx_s;
    logic             free_vld_s;
    logic             alloc_fire_s;
    rel_kind_e        rel_kind_s;

    // Tag choice looks only at the registered bitmap: a slot freed this cycle is not reusable until next cycle.
    rv_priority_encoder #(
        .N (DEPTH)
    ) u_free_enc (
        .req_i   (~used_q),
        .index_o (free_idx_s),
        .valid_o (free_vld_s)
    );

    assign full         = (count_q == (TAGW + 1)'(DEPTH));
    assign empty        = (count_q == {(TAGW + 1){1'b0}});
    assign count        = count_q;
    assign alloc_ready  = ~full;
    assign alloc_tag    = free_vld_s ? free_idx_s : {TAGW{1'b0}};
    assign err_release  = err_q;
    assign release_data = mem_q[release_tag];

    assign alloc_fire_s = alloc_valid & alloc_ready;
    assign rel_kind_s   = classify_release(release_valid, used_q[release_tag]);

    // Next occupancy, count and error flag; alloc and a valid release never share a slot.
    always_comb begin
        used_d  = used_q;
        count_d = count_q;
        err_d   = err_q;
        if (alloc_fire_s) begin
            used_d[alloc_tag] = 1'b1;
        end else begin
            used_d = used_d;
        end
        case (rel_kind_s)
            REL_OK:  used_d[release_tag] = 1'b0;
            REL_BAD: err_d = 1'b1;
            default: err_d = err_q;
        endcase
        case ({alloc_fire_s, rel_kind_s == REL_OK})
            2'b10:   count_d = count_q + (TAGW + 1)'(1);
            2'b01:   count_d = count_q - (TAGW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            used_q  <= {DEPTH{1'b0}};
            count_q <= {(TAGW + 1){1'b0}};
            err_q   <= 1'b0;
        end else begin
            used_q  <= used_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Metadata storage is deliberately left unreset so it maps onto plain LUTRAM/flops.
    always_ff @(posedge clk) begin
        if (alloc_fire_s) begin
            mem_q[alloc_tag] <= alloc_data;
        end else begin
            mem_q[alloc_tag] <= mem_q[alloc_tag];
        end
    end

endmodule

// File: tb/tb_rv_fpu_tag_buffer.sv
// Directed, table-driven bench for rv_fpu_tag_buffer (TAGW=2, DATAW=64).
module tb_rv_fpu_tag_buffer;

    logic        clk;
    logic        reset;
    logic        alloc_valid;
    logic [63:0] alloc_data;
    logic        alloc_ready;
    logic [1:0]  alloc_tag;
    logic        release_valid;
    logic [1:0]  release_tag;
    logic [63:0] release_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        err_release;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        av;
        logic [63:0] ad;
        logic        rv;
        logic [1:0]  rt;
        logic        e_ready;
        logic [1:0]  e_tag;
        logic [2:0]  e_count;
        logic        chk_rd;
        logic [63:0] e_rd;
        logic        e_err;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    rv_fpu_tag_buffer #(
        .TAGW  (2),
        .DATAW (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_data    (alloc_data),
        .alloc_ready   (alloc_ready),
        .alloc_tag     (alloc_tag),
        .release_valid (release_valid),
        .release_tag   (release_tag),
        .release_data  (release_data),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .err_release   (err_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic av, input logic [63:0] ad, input logic rv,
                                input logic [1:0] rt, input logic er, input logic [1:0] et,
                                input logic [2:0] ec, input logic cd, input logic [63:0] ed,
                                input logic ee);
        vec_t v;
        v.av = av; v.ad = ad; v.rv = rv; v.rt = rt;
        v.e_ready = er; v.e_tag = et; v.e_count = ec;
        v.chk_rd = cd; v.e_rd = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic er, input logic [1:0] et,
                             input logic [2:0] ec, input logic ee);
        chk({tag, " alloc_ready"}, 64'(alloc_ready), 64'(er));
        chk({tag, " alloc_tag"},   64'(alloc_tag),   64'(et));
        chk({tag, " count"},       64'(count),       64'(ec));
        chk({tag, " full"},        64'(full),        64'(ec == 3'd4));
        chk({tag, " empty"},       64'(empty),       64'(ec == 3'd0));
        chk({tag, " err_release"}, 64'(err_release), 64'(ee));
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        alloc_valid   = 1'b0;
        alloc_data    = 64'd0;
        release_valid = 1'b0;
        release_tag   = 2'd0;

        // Expected values are the outputs seen in the cycle the row's inputs are applied.
        //          av   data        rv   rt    rdy   tag   cnt   chkrd rd          err
        vecs[0]  = mk(1'b1, 64'hA0, 1'b0, 2'd0, 1'b1, 2'd0, 3'd0, 1'b0, 64'h0,  1'b0);
        vecs[1]  = mk(1'b1, 64'hA1, 1'b0, 2'd0, 1'b1, 2'd1, 3'd1, 1'b1, 64'hA0, 1'b0);
        vecs[2]  = mk(1'b1, 64'hA2, 1'b0, 2'd0, 1'b1, 2'd2, 3'd2, 1'b0, 64'h0,  1'b0);
        vecs[3]  = mk(1'b1, 64'hA3, 1'b0, 2'd0, 1'b1, 2'd3, 3'd3, 1'b0, 64'h0,  1'b0);
        vecs[4]  = mk(1'b1, 64'hA4, 1'b0, 2'd3, 1'b0, 2'd0, 3'd4, 1'b1, 64'hA3, 1'b0);
        vecs[5]  = mk(1'b0, 64'h0,  1'b1, 2'd2, 1'b0, 2'd0, 3'd4, 1'b1, 64'hA2, 1'b0);
        vecs[6]  = mk(1'b1, 64'hB0, 1'b0, 2'd2, 1'b1, 2'd2, 3'd3, 1'b0, 64'h0,  1'b0);
        vecs[7]  = mk(1'b0, 64'h0,  1'b1, 2'd0, 1'b0, 2'd0, 3'd4, 1'b1, 64'hA0, 1'b0);
        vecs[8]  = mk(1'b0, 64'h0,  1'b1, 2'd3, 1'b1, 2'd0, 3'd3, 1'b1, 64'hA3, 1'b0);
        vecs[9]  = mk(1'b0, 64'h0,  1'b0, 2'd2, 1'b1, 2'd0, 3'd2, 1'b1, 64'hB0, 1'b0);
        vecs[10] = mk(1'b1, 64'hC0, 1'b0, 2'd0, 1'b1, 2'd0, 3'd2, 1'b0, 64'h0,  1'b0);
        vecs[11] = mk(1'b1, 64'hC3, 1'b0, 2'd0, 1'b1, 2'd3, 3'd3, 1'b1, 64'hC0, 1'b0);
        vecs[12] = mk(1'b1, 64'hD1, 1'b1, 2'd1, 1'b0, 2'd0, 3'd4, 1'b1, 64'hA1, 1'b0);
        vecs[13] = mk(1'b1, 64'hD1, 1'b0, 2'd1, 1'b1, 2'd1, 3'd3, 1'b0, 64'h0,  1'b0);
        vecs[14] = mk(1'b0, 64'h0,  1'b0, 2'd1, 1'b0, 2'd0, 3'd4, 1'b1, 64'hD1, 1'b0);
        vecs[15] = mk(1'b0, 64'h0,  1'b1, 2'd2, 1'b0, 2'd0, 3'd4, 1'b1, 64'hB0, 1'b0);
        vecs[16] = mk(1'b0, 64'h0,  1'b1, 2'd3, 1'b1, 2'd2, 3'd3, 1'b1, 64'hC3, 1'b0);
        vecs[17] = mk(1'b1, 64'hE2, 1'b1, 2'd0, 1'b1, 2'd2, 3'd2, 1'b1, 64'hC0, 1'b0);
        vecs[18] = mk(1'b0, 64'h0,  1'b0, 2'd2, 1'b1, 2'd0, 3'd2, 1'b1, 64'hE2, 1'b0);
        vecs[19] = mk(1'b0, 64'h0,  1'b1, 2'd3, 1'b1, 2'd0, 3'd2, 1'b0, 64'h0,  1'b0);
        vecs[20] = mk(1'b0, 64'h0,  1'b0, 2'd0, 1'b1, 2'd0, 3'd2, 1'b0, 64'h0,  1'b1);
        vecs[21] = mk(1'b0, 64'h0,  1'b1, 2'd0, 1'b1, 2'd0, 3'd2, 1'b0, 64'h0,  1'b1);
        vecs[22] = mk(1'b0, 64'h0,  1'b1, 2'd1, 1'b1, 2'd0, 3'd2, 1'b1, 64'hD1, 1'b1);
        vecs[23] = mk(1'b0, 64'h0,  1'b0, 2'd2, 1'b1, 2'd0, 3'd1, 1'b1, 64'hE2, 1'b1);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            alloc_valid   = vecs[i].av;
            alloc_data    = vecs[i].ad;
            release_valid = vecs[i].rv;
            release_tag   = vecs[i].rt;
            @(negedge clk);
            chk_state($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_tag,
                      vecs[i].e_count, vecs[i].e_err);
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d release_data", i), release_data, vecs[i].e_rd);
            end
        end

        // Asynchronous reset in the middle of a cycle with traffic pending.
        @(posedge clk);
        #1;
        alloc_valid = 1'b1;
        alloc_data  = 64'hEE;
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_reset", 1'b1, 2'd0, 3'd0, 1'b0);
        @(negedge clk);
        reset       = 1'b0;
        alloc_valid = 1'b0;
        @(negedge clk);
        chk_state("post_reset", 1'b1, 2'd0, 3'd0, 1'b0);

        // First grant after reset restarts at tag 0, data readable the next cycle.
        @(posedge clk);
        #1;
        alloc_valid = 1'b1;
        alloc_data  = 64'hF0;
        @(negedge clk);
        chk_state("realloc_grant", 1'b1, 2'd0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        release_tag = 2'd0;
        @(negedge clk);
        chk_state("realloc_after", 1'b1, 2'd1, 3'd1, 1'b0);
        chk("realloc release_data", release_data, 64'hF0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv_fpu_tag_buffer.md
# rv_fpu_tag_buffer

Tag allocator and metadata store directly upstream of the FPU core wrapper. Each FPU request receives a free `TAGW`-bit tag, and its per-instruction metadata (warp id, PC, rd, thread mask, packed as `DATAW` bits) is parked here. The tag travels through the FPU as `tag_in`/`tag_out`. When the FPU emits a result, the commit logic presents `tag_out` here to recover the metadata and free the slot. This bounds in-flight FPU operations to `2**TAGW` and stalls issue when all tags are in use.

## Interface
Parameters:
- `TAGW`, 2, tag width; `DEPTH = 2**TAGW` slots.
- `DATAW`, 64, metadata width per slot.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `alloc_valid`  in  1  issue has an FPU request needing a tag.
- `alloc_data`  in  DATAW  metadata to store with the request.
- `alloc_ready`  out  1  a free tag exists; allocation fires on `alloc_valid && alloc_ready`.
- `alloc_tag`  out  TAGW  tag granted this cycle; drives FPU `tag_in`.
- `release_valid`  in  1  FPU result accepted (`valid_out && ready_out`).
- `release_tag`  in  TAGW  tag of the completing result.
- `release_data`  out  DATAW  metadata of `release_tag`, combinational read.
- `count`  out  TAGW+1  number of allocated slots.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `err_release`  out  1  sticky flag: a release hit a slot that was not allocated.

## Operation
- State:
  - `used[DEPTH-1:0]` occupancy bitmap.
  - `mem[DEPTH][DATAW]` metadata storage.
  - `count` register.
  - `err_release` register.
- Allocation:
  - `alloc_tag` = lowest index `i` with `used[i]==0`, taken from the registered bitmap.
  - `alloc_ready = ~full`.
  - On fire: `used[alloc_tag]<=1` and `mem[alloc_tag]<=alloc_data`.
  - When `full`, `alloc_tag` is 0 and is meaningless.
- Release:
  - `release_data = mem[release_tag]` at all times, independent of `release_valid`.
  - On `release_valid`: if `used[release_tag]`, then `used[release_tag]<=0`.
  - Otherwise the release is ignored (bitmap and `count` unchanged) and `err_release<=1`. The flag clears only on reset.
- Count:
  - `count` += alloc fire, −= valid release (a release to a used slot).
  - Simultaneous fire and valid release leave `count` unchanged.
- Simultaneous events:
  - A slot freed in cycle N becomes allocatable in cycle N+1, not N. Allocation uses the pre-release bitmap, so there is no combinational release→alloc path.
  - Alloc and release of different slots in the same cycle are both applied.
  - Alloc and release cannot target the same slot in one cycle: alloc targets free slots, a valid release targets a used slot.
- Full: with `count==DEPTH` and a release in cycle N, `alloc_ready` rises in cycle N+1.
- `alloc_data` is ignored when `alloc_valid` is low or `alloc_ready` is low.

## Timing
- Reset (asynchronous assert, released synchronously to `clk`):
  - `used=0`, `count=0`, `full=0`, `empty=1`, `alloc_ready=1`, `alloc_tag=0`, `err_release=0`.
  - `mem` is not reset.
- Alloc-to-storage latency is 1 cycle. `release_data` for a tag allocated in cycle N is valid from cycle N+1 onward.
- All outputs except `release_data` are functions of registered state only. `release_data` is combinational from `release_tag`.
- Reset mid-operation discards all in-flight tags. The FPU is reset by the same `reset`, so no stale release can arrive afterwards.

## Structure
- `DEPTH` is a localparam in this block.
- No new package entries are needed.
- `DATAW` is sized at instantiation from existing `RV_define.vh` widths (`NW_BITS`, `NUM_THREADS`, `NR_BITS`, PC width).
- One sub-module: `rv_priority_encoder` (parameter `N`; input `N`-bit request; outputs index and `valid`). It is instantiated on `~used` for tag selection and is reusable elsewhere.
- Storage is a plain register array, small enough for LUTRAM/flops.

## Test plan
- **Reset state:** after reset, `alloc_ready=1`, `empty=1`, `count=0`, `alloc_tag=0`, `err_release=0`.
- **Fill to full (TAGW=2):** 4 back-to-back allocs with data 0xA0..0xA3 → tags 0,1,2,3; `count=4`, `full=1`, `alloc_ready=0`. A 5th `alloc_valid` held high is not accepted.
- **Out-of-order release:**
  - Release tag 2 → `release_data=0xA2`, `count=3` next cycle.
  - Next alloc with 0xB0 gets tag 2.
  - Then release 0 and then 3 → data 0xA0 and 0xA3.
- **Simultaneous events, full:** with `full`, alloc held high and release tag 1 in cycle N → no grant in N; grant of tag 1 in N+1; `count` returns to 4.
- **Simultaneous events, not full:** with `count=2` (tags 0,1 used), alloc and release tag 0 in the same cycle → grant tag 2, `count` stays 2, tag 0 is free next cycle.
- **Bad release:** release tag 3 while unused → `err_release=1` sticky, `count` and `used` unchanged. An asynchronous reset mid-stream clears everything within the same cycle it asserts.
